// File: rtl/counter_read_snapshot_if.sv
// Register-bus side of the counter read path: decoder strobes in, read data
// and snapshot status out.
//
// Handshake: each *_sel strobe is a single-cycle request sampled at a sys_clk
// edge. There is no back-pressure (the block is always ready). rd_ack pulses
// high for exactly one cycle, one cycle after a read strobe, and rdata_cnt is
// valid while rd_ack is high. rdata_cnt holds its last value otherwise.
interface counter_read_snapshot_if;
  logic        tdr0_rd_sel;
  logic        tdr1_rd_sel;
  logic        tdr0_wr_sel;
  logic        tdr1_wr_sel;
  logic [31:0] rdata_cnt;
  logic        rd_ack;
  logic        snap_valid;
  logic        snap_miss;

  // Register decoder side: issues strobes, receives read data and status.
  modport master (
    output tdr0_rd_sel, tdr1_rd_sel, tdr0_wr_sel, tdr1_wr_sel,
    input  rdata_cnt, rd_ack, snap_valid, snap_miss
  );

  // Snapshot block side.
  modport slave (
    input  tdr0_rd_sel, tdr1_rd_sel, tdr0_wr_sel, tdr1_wr_sel,
    output rdata_cnt, rd_ack, snap_valid, snap_miss
  );
endinterface

// File: rtl/counter_read_snapshot.sv
// Read-side companion to the 64-bit timer counter. A TDR0 read returns the
// low word and latches the high word into a shadow register so that the
// following TDR1 read sees a value coherent with the low word, even if a
// carry into the high word happened in between. The shadow expires after
// HOLD_TIMEOUT idle cycles (0 = never) or on any write to TDR0/TDR1.
module counter_read_snapshot #(
  parameter int unsigned HOLD_TIMEOUT = 1024,
  parameter int unsigned TO_W         = 11
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [63:0]               cnt,
  counter_read_snapshot_if.slave    bus,
  output logic                      state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // Last idle count before expiry; unused when HOLD_TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((HOLD_TIMEOUT == 0) ? 0 : HOLD_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  state_t          state_q, state_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            miss_q, miss_d;

  logic rd0;
  logic rd1;
  logic any_wr;
  logic any_strobe;

  // TDR0 read wins over a same-cycle TDR1 read.
  assign rd0        = bus.tdr0_rd_sel;
  assign rd1        = bus.tdr1_rd_sel & ~bus.tdr0_rd_sel;
  assign any_wr     = bus.tdr0_wr_sel | bus.tdr1_wr_sel;
  assign any_strobe = bus.tdr0_rd_sel | bus.tdr1_rd_sel | any_wr;

  // Next-state, read-data and status decode.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    to_d     = '0;
    rdata_d  = rdata_q;
    ack_d    = rd0 | rd1;
    miss_d   = miss_q;

    // Read data: the shadow is only returned for a clean TDR1 read in HELD;
    // any write in the same cycle makes the read fall back to the live value.
    if (rd0) begin
      rdata_d = cnt[31:0];
    end else if (rd1) begin
      if ((state_q == HELD) && !any_wr) begin
        rdata_d = shadow_q;
      end else begin
        rdata_d = cnt[63:32];
      end
    end

    // Sticky miss flag: a TDR1 read with no snapshot pending.
    if (rd0) begin
      miss_d = 1'b0;
    end else if (rd1 && (state_q == IDLE)) begin
      miss_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rd0 && !any_wr) begin
          state_d  = HELD;
          shadow_d = cnt[63:32];
        end
      end
      HELD: begin
        if (any_wr) begin
          state_d = IDLE;
        end else if (rd0) begin
          shadow_d = cnt[63:32];
        end else if (rd1) begin
          state_d = IDLE;
        end else if (!any_strobe) begin
          if ((HOLD_TIMEOUT != 0) && (to_q == TO_LAST)) begin
            state_d = IDLE;
          end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
          end else begin
            to_d = to_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow, timeout and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      to_q     <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      to_q     <= to_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.rdata_cnt  = rdata_q;
  assign bus.rd_ack     = ack_q;
  assign bus.snap_valid = (state_q == HELD);
  assign bus.snap_miss  = miss_q;
  assign state_dbg      = state_q;

endmodule
